mem_responder: RTL and testbench
================================

# mem_responder

Dual-port memory model that sits on the far side of the CPU's instruction and data memory interfaces. It accepts `readM`/`writeM` requests on each port independently and answers each after a fixed, parameterized latency with a one-cycle `ready` pulse. For reads, it drives the shared bidirectional data bus only during that pulse. It is the testbench/system-level target that replaces the ideal zero-latency memory, so stalling logic in the CPU can be exercised.

## Interface
- `WORD_SIZE`, default 16: data and address width.
- `ADDR_BITS`, default 8: array depth is 2^ADDR_BITS words.
- `LATENCY`, default 2: edges from request acceptance to response; legal range is ≥1.

- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `i_readM`  in  1  instruction-port read request.
- `i_writeM`  in  1  instruction-port write request.
- `i_address`  in  WORD_SIZE  instruction-port address.
- `i_data`  inout  WORD_SIZE  instruction-port data bus.
- `i_ready`  out  1  one-cycle response strobe, instruction port.
- `d_readM`, `d_writeM`, `d_address`, `d_data`, `d_ready`: identical set for the data port.

## Operation
- The two ports run as independent FSMs with states IDLE, BUSY and RESP.
- **IDLE**
  - On an edge with `readM|writeM` high, latch the address, the op and (for a write) the data bus value. Go to BUSY with `cnt=LATENCY-1`.
  - If `readM` and `writeM` are both high, the request is treated as a write.
- **BUSY**
  - On each edge, if `cnt==0` go to RESP; otherwise decrement `cnt`.
- **Entering RESP**
  - Read: capture `mem[addr]` into the port's read register.
  - Write: commit latched data to `mem[addr]`.
- **RESP**
  - `ready=1`.
  - Read: the port drives its data bus from the read register.
  - At the next edge, go unconditionally to IDLE. No request is accepted in RESP.
- **Bus drive**
  - The data bus is driven only in RESP with op=read. It is high-Z in all other states.
- **Address**
  - Only `address[ADDR_BITS-1:0]` is used; upper bits are ignored, so addresses alias modulo depth.
- **Simultaneous events**
  - Both ports commit writes to the same address on the same edge: the data port wins.
  - A read capture on the same edge as a write commit to the same address returns the old value.
  - Requests on different ports never block each other.
- **Reset**
  - Reset is asynchronous. Both FSMs go to IDLE, `cnt=0`, and `i_ready`/`d_ready` go to 0.
  - Both buses are released to Z immediately.
  - A pending write is discarded and not committed.
  - Array contents are retained (not cleared).

## Timing
- Reset values: `i_ready=0`, `d_ready=0`, `i_data=Z`, `d_data=Z`, both FSMs in IDLE.
- Accept at edge E0 → `ready` high for exactly the cycle E(LATENCY)…E(LATENCY+1).
- Read data is valid on the bus for that same cycle.
- The initiator holds its request and address until it samples `ready`, and drops the request by edge E(LATENCY+1).
- If the request is still high, it is re-accepted at E(LATENCY+2). Maximum throughput per port is one access per LATENCY+2 cycles.
- Write data is sampled at E0 only; later bus changes are ignored.
- `ready` is registered, with no combinational path from request inputs.

## Structure
- Shared package `mem_pkg` holds:
  - the state encoding (IDLE/BUSY/RESP);
  - the op encoding (READ/WRITE);
  - the port-request record.
- `WORD_SIZE` comes from the existing global define.
- Sub-module `mem_port_fsm` is instantiated twice. It owns the FSM, the counter, latched addr/op/wdata, the `ready` register and the tri-state enable.
- Top level `mem_responder` owns:
  - the array;
  - the two-writer commit with data-port priority;
  - read-register capture;
  - bus tri-states.

## Test plan
All scenarios use `LATENCY=2` and `ADDR_BITS=8`.
- **Basic write/read:** after reset, d-write 0xBEEF to 0x0010 accepted at E0 → `d_ready` high only in E2…E3. Then d-read 0x0010 → `d_data`=0xBEEF during its `ready` cycle and Z on every other cycle.
- **Aliasing:** i-read 0x0110 → `i_data`=0xBEEF.
- **Write collision:** d-write 0x1111 and i-write 0x2222, both to 0x0020, accepted on the same edge → both `ready`s pulse together. A subsequent read of 0x0020 returns 0x1111.
- **Read/write same edge:** 0x0030 preloaded with 0x0005. i-read 0x0030 and d-write 0x0007 to 0x0030 accepted on the same edge → `i_data`=0x0005. The next read returns 0x0007.
- **Reset mid-write:** 0x0040 holds 0x1234. d-write 0x9999 accepted, then `reset` pulsed mid-cycle during BUSY → `d_ready` never asserts, the bus is Z immediately, and a later read of 0x0040 returns 0x1234.
- **Held request:** `i_readM` held high continuously → `i_ready` pulses every 4 cycles, never in adjacent cycles.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared types for the dual-port memory responder.
//   state_e    : per-port FSM state (IDLE/BUSY/RESP)
//   op_e       : latched operation (READ/WRITE)
//   port_req_t : decoded request seen by a port FSM in IDLE
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  typedef struct packed {
    logic valid;
    op_e  op;
  } port_req_t;

endpackage

// File: rtl/mem_port_fsm.sv
// mem_port_fsm: one memory port's request sequencer.
// Accepts a read/write in IDLE, waits LATENCY edges, then spends one cycle in
// RESP with ready high. Latches address/op/write data at acceptance.
// Ports:
//   clk, reset        : clock, async active-high reset
//   read_m, write_m   : request strobes (write wins if both high)
//   address, bus_in   : request address and current data-bus value
//   addr, op, wdata   : latched request, valid from BUSY onward
//   fire_c            : high on the cycle whose closing edge enters RESP
//   ready             : registered response strobe
//   drive_en          : registered bus output enable (RESP of a read)
module mem_port_fsm
  import mem_pkg::*;
#(
  parameter int unsigned WORD_SIZE = `WORD_SIZE,
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 read_m,
  input  logic                 write_m,
  input  logic [WORD_SIZE-1:0] address,
  input  logic [WORD_SIZE-1:0] bus_in,
  output logic [ADDR_BITS-1:0] addr,
  output op_e                  op,
  output logic [WORD_SIZE-1:0] wdata,
  output logic                 fire_c,
  output logic                 ready,
  output logic                 drive_en
);

  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_e           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  port_req_t        req_c;
  logic             accept_c;
  logic             ready_nx;
  logic             drive_nx;

  // Upper address bits alias onto the array and are deliberately dropped.
  if (WORD_SIZE > ADDR_BITS) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^address[WORD_SIZE-1:ADDR_BITS];
  end

  // Request decode: simultaneous read+write is treated as a write.
  always_comb begin
    req_c.valid = read_m | write_m;
    req_c.op    = write_m ? OP_WRITE : OP_READ;
  end

  // State register plus request latches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      ready    <= 1'b0;
      drive_en <= 1'b0;
      addr     <= '0;
      op       <= OP_READ;
      wdata    <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      ready    <= ready_nx;
      drive_en <= drive_nx;
      if (accept_c) begin
        addr  <= address[ADDR_BITS-1:0];
        op    <= req_c.op;
        wdata <= bus_in;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_c.valid) begin
          accept_c = 1'b1;
          state_nx = ST_BUSY;
          cnt_nx   = CNT_INIT;
        end
      end
      ST_BUSY: begin
        if (cnt == '0) state_nx = ST_RESP;
        else           cnt_nx   = cnt - CNT_W'(1);
      end
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Outputs: ready/drive are computed from the next state so they register
  // in step with entering RESP.
  always_comb begin
    fire_c   = (state == ST_BUSY) && (cnt == '0);
    ready_nx = (state_nx == ST_RESP);
    drive_nx = (state_nx == ST_RESP) && (op == OP_READ);
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: dual-port fixed-latency memory model for the CPU's
// instruction and data interfaces.
// Ports (per port, prefix i_ = instruction, d_ = data):
//   clk, reset          : clock, async active-high reset
//   *_readM, *_writeM   : request strobes
//   *_address           : word address (low ADDR_BITS used)
//   *_data              : bidirectional data bus, driven only in read response
//   *_ready             : one-cycle registered response strobe
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned WORD_SIZE = `WORD_SIZE,
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_readM,
  input  logic                 i_writeM,
  input  logic [WORD_SIZE-1:0] i_address,
  inout  wire  [WORD_SIZE-1:0] i_data,
  output logic                 i_ready,
  input  logic                 d_readM,
  input  logic                 d_writeM,
  input  logic [WORD_SIZE-1:0] d_address,
  inout  wire  [WORD_SIZE-1:0] d_data,
  output logic                 d_ready
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;

  logic [WORD_SIZE-1:0] mem [DEPTH];

  logic [ADDR_BITS-1:0] i_addr, d_addr;
  op_e                  i_op, d_op;
  logic [WORD_SIZE-1:0] i_wdata, d_wdata;
  logic                 i_fire_c, d_fire_c;
  logic                 i_drive, d_drive;
  logic [WORD_SIZE-1:0] i_rdata, d_rdata;

  mem_port_fsm #(
    .WORD_SIZE(WORD_SIZE), .ADDR_BITS(ADDR_BITS), .LATENCY(LATENCY)
  ) u_i_port (
    .clk(clk), .reset(reset),
    .read_m(i_readM), .write_m(i_writeM), .address(i_address), .bus_in(i_data),
    .addr(i_addr), .op(i_op), .wdata(i_wdata),
    .fire_c(i_fire_c), .ready(i_ready), .drive_en(i_drive)
  );

  mem_port_fsm #(
    .WORD_SIZE(WORD_SIZE), .ADDR_BITS(ADDR_BITS), .LATENCY(LATENCY)
  ) u_d_port (
    .clk(clk), .reset(reset),
    .read_m(d_readM), .write_m(d_writeM), .address(d_address), .bus_in(d_data),
    .addr(d_addr), .op(d_op), .wdata(d_wdata),
    .fire_c(d_fire_c), .ready(d_ready), .drive_en(d_drive)
  );

  // Write commit; the data port is written last so it wins a same-address tie.
  // No reset: contents survive reset, and a reset before fire discards the write.
  always_ff @(posedge clk) begin
    if (i_fire_c && (i_op == OP_WRITE)) mem[i_addr] <= i_wdata;
    if (d_fire_c && (d_op == OP_WRITE)) mem[d_addr] <= d_wdata;
  end

  // Read capture samples the pre-edge array, so a same-edge write returns old data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      if (i_fire_c && (i_op == OP_READ)) i_rdata <= mem[i_addr];
      if (d_fire_c && (d_op == OP_READ)) d_rdata <= mem[d_addr];
    end
  end

  assign i_data = i_drive ? i_rdata : {WORD_SIZE{1'bz}};
  assign d_data = d_drive ? d_rdata : {WORD_SIZE{1'bz}};

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder (LATENCY=2, ADDR_BITS=8).
// Expected responses are queued per port when a request is driven and are
// matched by a negedge monitor; every other cycle must show ready low and an
// undriven (pulled-up) bus.
module tb_mem_responder;

  localparam int unsigned LAT = 2;
  localparam logic [15:0] BUS_IDLE = 16'hFFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_readM, i_writeM, d_readM, d_writeM;
  logic [15:0] i_address, d_address;
  logic        i_ready, d_ready;
  tri1  [15:0] i_data, d_data;
  logic [15:0] i_drv, d_drv;
  logic        i_drv_en, d_drv_en;
  logic        mon_en;

  assign i_data = i_drv_en ? i_drv : 16'bz;
  assign d_data = d_drv_en ? d_drv : 16'bz;

  always #5 clk = ~clk;

  mem_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .i_readM(i_readM), .i_writeM(i_writeM), .i_address(i_address),
    .i_data(i_data), .i_ready(i_ready),
    .d_readM(d_readM), .d_writeM(d_writeM), .d_address(d_address),
    .d_data(d_data), .d_ready(d_ready)
  );

  typedef struct {
    bit          is_read;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t i_q[$];
  exp_t d_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Response monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset && mon_en) begin
      if (i_q.size() > 0 && i_q[0].due == cyc) begin
        check_eq("i_ready_pulse", 16'(i_ready), 16'd1);
        check_eq("i_bus_resp", i_data, i_q[0].is_read ? i_q[0].data : BUS_IDLE);
        void'(i_q.pop_front());
      end else begin
        check_eq("i_ready_idle", 16'(i_ready), 16'd0);
        if (!i_drv_en) check_eq("i_bus_z", i_data, BUS_IDLE);
      end
      if (d_q.size() > 0 && d_q[0].due == cyc) begin
        check_eq("d_ready_pulse", 16'(d_ready), 16'd1);
        check_eq("d_bus_resp", d_data, d_q[0].is_read ? d_q[0].data : BUS_IDLE);
        void'(d_q.pop_front());
      end else begin
        check_eq("d_ready_idle", 16'(d_ready), 16'd0);
        if (!d_drv_en) check_eq("d_bus_z", d_data, BUS_IDLE);
      end
    end
  end

  // Issue one request on either or both ports (called just after a posedge).
  task automatic issue(input bit use_i, input bit iw, input logic [15:0] ia,
                       input logic [15:0] iwd, input logic [15:0] iexp,
                       input bit use_d, input bit dw, input logic [15:0] da,
                       input logic [15:0] dwd, input logic [15:0] dexp);
    if (use_i) begin
      i_readM = !iw; i_writeM = iw; i_address = ia;
      if (iw) begin i_drv = iwd; i_drv_en = 1'b1; end
      i_q.push_back('{is_read: !iw, data: iexp, due: cyc + 1 + LAT});
    end
    if (use_d) begin
      d_readM = !dw; d_writeM = dw; d_address = da;
      if (dw) begin d_drv = dwd; d_drv_en = 1'b1; end
      d_q.push_back('{is_read: !dw, data: dexp, due: cyc + 1 + LAT});
    end
    @(posedge clk); #1;
    i_readM = 1'b0; i_writeM = 1'b0; d_readM = 1'b0; d_writeM = 1'b0;
    // Scramble write data after acceptance; it must not be picked up.
    i_drv = ~i_drv; d_drv = ~d_drv;
    @(posedge clk); #1;
    i_drv_en = 1'b0; d_drv_en = 1'b0;
    repeat (LAT) @(posedge clk);
    #1;
    check_eq("i_drain", 16'(i_q.size()), 16'd0);
    check_eq("d_drain", 16'(d_q.size()), 16'd0);
    i_q.delete(); d_q.delete();
  endtask

  task automatic wr_d(input logic [15:0] a, input logic [15:0] v);
    issue(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1, a, v, 16'h0);
  endtask
  task automatic rd_d(input logic [15:0] a, input logic [15:0] v);
    issue(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0, a, 16'h0, v);
  endtask
  task automatic rd_i(input logic [15:0] a, input logic [15:0] v);
    issue(1'b1, 1'b0, a, 16'h0, v, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    i_readM = 1'b0; i_writeM = 1'b0; i_address = '0; i_drv = '0; i_drv_en = 1'b0;
    d_readM = 1'b0; d_writeM = 1'b0; d_address = '0; d_drv = '0; d_drv_en = 1'b0;
    mon_en = 1'b1;
    reset = 1'b1;
    #3;
    check_eq("rst_i_ready", 16'(i_ready), 16'd0);
    check_eq("rst_d_ready", 16'(d_ready), 16'd0);
    check_eq("rst_i_bus", i_data, BUS_IDLE);
    check_eq("rst_d_bus", d_data, BUS_IDLE);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Basic write then read.
    wr_d(16'h0010, 16'hBEEF);
    rd_d(16'h0010, 16'hBEEF);

    // Upper address bits alias.
    rd_i(16'h0110, 16'hBEEF);

    // Same-edge writes to one address: data port wins.
    issue(1'b1, 1'b1, 16'h0020, 16'h2222, 16'h0, 1'b1, 1'b1, 16'h0020, 16'h1111, 16'h0);
    rd_d(16'h0020, 16'h1111);
    rd_i(16'h0020, 16'h1111);

    // Read and write of one address on the same edge: read sees old data.
    wr_d(16'h0030, 16'h0005);
    issue(1'b1, 1'b0, 16'h0030, 16'h0, 16'h0005, 1'b1, 1'b1, 16'h0030, 16'h0007, 16'h0);
    rd_i(16'h0030, 16'h0007);

    // Reset while a write is pending, and reset while a read is responding.
    wr_d(16'h0040, 16'h1234);
    mon_en = 1'b0;
    d_writeM = 1'b1; d_address = 16'h0040; d_drv = 16'h9999; d_drv_en = 1'b1;
    @(posedge clk); #1;
    d_writeM = 1'b0; d_drv_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_eq("rstw_d_ready", 16'(d_ready), 16'd0);
    check_eq("rstw_d_bus", d_data, BUS_IDLE);
    @(posedge clk); #1 reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check_eq("rstw_no_ready", 16'(d_ready), 16'd0);
    end
    @(posedge clk); #1;
    d_readM = 1'b1; d_address = 16'h0040;
    @(posedge clk); #1;
    d_readM = 1'b0;
    repeat (LAT) @(posedge clk);
    #1;
    check_eq("rstr_d_ready_pre", 16'(d_ready), 16'd1);
    check_eq("rstr_d_bus_pre", d_data, 16'h1234);
    #2 reset = 1'b1;
    #1;
    check_eq("rstr_d_ready", 16'(d_ready), 16'd0);
    check_eq("rstr_d_bus", d_data, BUS_IDLE);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    rd_d(16'h0040, 16'h1234);

    // Held read request: one response every LAT+2 cycles.
    c0 = cyc;
    i_readM = 1'b1; i_address = 16'h0010;
    for (int k = 0; k < 3; k++)
      i_q.push_back('{is_read: 1'b1, data: 16'hBEEF, due: c0 + 1 + LAT + k * (LAT + 2)});
    repeat (3 * (LAT + 2)) @(posedge clk);
    #1 i_readM = 1'b0;
    repeat (LAT + 2) @(posedge clk);
    #1;
    check_eq("held_drain", 16'(i_q.size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
